// File: rtl/e203_exu_fpu_fmis_arb.sv
// ---------------------------------------------------------------------------
// e203_exu_fpu_fmis_arb
//
// Purpose:
//   Round-robin arbiter that funnels two requesters onto the single shared
//   fmis move datapath through a one-entry output buffer. The accepted op
//   appears on the output one cycle after acceptance. While the consumer keeps
//   o_ready high, the buffer can take a new op every cycle.
//
// Ports:
//   clk                 single clock, rising-edge
//   rst                 synchronous active-high reset
//   flush               synchronous pipeline flush, drops the buffered op
//   r0_valid/r0_ready   requester 0 handshake
//   r0_data, r0_tag     requester 0 operand (rs1) and destination tag
//   r1_*                requester 1, same meaning as r0_*
//   o_valid/o_ready     writeback handshake toward the fmis_mv datapath
//   o_data, o_tag       buffered operand and tag of the granted op
//   o_src               index of the requester that supplied the buffered op
//   busy                high whenever an op is buffered (mirror of o_valid)
// ---------------------------------------------------------------------------
module e203_exu_fpu_fmis_arb #(
  parameter int DW = 32,
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [DW-1:0] r0_data,
  input  logic [TW-1:0] r0_tag,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [DW-1:0] r1_data,
  input  logic [TW-1:0] r1_tag,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [TW-1:0] o_tag,
  output logic          o_src,
  output logic          busy
);

  // Round-robin pointer: requester index currently holding priority.
  logic ptr;
  logic can_accept;
  logic acc0;
  logic acc1;

  // The buffer can take a new op when it is empty, or when it is full and
  // its contents leave this cycle. Flush and reset block any acceptance.
  // Readies are derived only from the other requester's valid, so a
  // requester never sees its own valid fed back into its ready.
  always_comb begin
    can_accept = (!o_valid || o_ready) && !flush && !rst;
    r0_ready   = can_accept && (!ptr || !r1_valid);
    r1_ready   = can_accept && ( ptr || !r0_valid);
    // The ready terms are mutually exclusive when both requesters are valid,
    // so at most one of these can fire in a cycle.
    acc0       = r0_valid && r0_ready;
    acc1       = r1_valid && r1_ready;
  end

  // Output buffer and priority pointer. An acceptance reloads the buffer
  // (which also covers back-to-back draining); otherwise a flush or a
  // completed output beat empties it. Payload registers only move on
  // acceptance, so they hold steady while empty or stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_tag   <= '0;
      o_src   <= 1'b0;
      ptr     <= 1'b0;
    end else if (acc0) begin
      o_valid <= 1'b1;
      o_data  <= r0_data;
      o_tag   <= r0_tag;
      o_src   <= 1'b0;
      ptr     <= 1'b1;
    end else if (acc1) begin
      o_valid <= 1'b1;
      o_data  <= r1_data;
      o_tag   <= r1_tag;
      o_src   <= 1'b1;
      ptr     <= 1'b0;
    end else if (flush || o_ready) begin
      o_valid <= 1'b0;
    end
  end

  assign busy = o_valid;

endmodule

// File: tb/tb_e203_exu_fpu_fmis_arb.sv
// ---------------------------------------------------------------------------
// tb_e203_exu_fpu_fmis_arb
//
// Self-checking bench for the two-requester fmis arbiter. A behavioural
// model (buffer contents plus priority pointer) follows the handshake rules,
// and each scenario task compares the DUT against the model or against fixed
// expected values.
// ---------------------------------------------------------------------------
module tb_e203_exu_fpu_fmis_arb;

  localparam int DW = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          r0_valid;
  logic          r0_ready;
  logic [DW-1:0] r0_data;
  logic [TW-1:0] r0_tag;
  logic          r1_valid;
  logic          r1_ready;
  logic [DW-1:0] r1_data;
  logic [TW-1:0] r1_tag;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic [TW-1:0] o_tag;
  logic          o_src;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [TW-1:0] m_tag;
  logic          m_src;
  logic          m_ptr;

  e203_exu_fpu_fmis_arb #(.DW(DW), .TW(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .r0_valid (r0_valid),
    .r0_ready (r0_ready),
    .r0_data  (r0_data),
    .r0_tag   (r0_tag),
    .r1_valid (r1_valid),
    .r1_ready (r1_ready),
    .r1_data  (r1_data),
    .r1_tag   (r1_tag),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_tag    (o_tag),
    .o_src    (o_src),
    .busy     (busy)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Model: requester k may hand over an op when nothing blocks the buffer
  // and either it holds priority or its competitor is idle.
  function automatic logic exp_ready(input logic k);
    logic other_valid;
    logic room;
    other_valid = k ? r0_valid : r1_valid;
    room        = !m_valid || o_ready;
    return !rst && !flush && room && ((m_ptr == k) || !other_valid);
  endfunction

  // Advance one clock: decide the grant from current inputs, step the model,
  // then move 1 unit past the edge so outputs are sampled away from it.
  task automatic tick();
    logic g0;
    logic g1;
    g0 = r0_valid && exp_ready(1'b0);
    g1 = r1_valid && exp_ready(1'b1);
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_tag = '0; m_src = 1'b0; m_ptr = 1'b0;
    end else if (g0) begin
      m_valid = 1'b1; m_data = r0_data; m_tag = r0_tag; m_src = 1'b0; m_ptr = 1'b1;
    end else if (g1) begin
      m_valid = 1'b1; m_data = r1_data; m_tag = r1_tag; m_src = 1'b1; m_ptr = 1'b0;
    end else if (flush || (m_valid && o_ready)) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input logic rs, input logic fl,
                       input logic v0, input logic [DW-1:0] d0, input logic [TW-1:0] t0,
                       input logic v1, input logic [DW-1:0] d1, input logic [TW-1:0] t1,
                       input logic ordy);
    rst = rs; flush = fl;
    r0_valid = v0; r0_data = d0; r0_tag = t0;
    r1_valid = v1; r1_data = d1; r1_tag = t1;
    o_ready = ordy;
  endtask

  task automatic reset_dut();
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  // Reset clears everything and blocks both requesters while asserted
  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 32'h1234_5678, 5'd9, 1'b1, 32'hCAFE_F00D, 5'd4, 1'b1);
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready got %b want 00", {r0_ready, r1_ready});
    end
    tick();
    tests_run++;
    if ({o_valid, busy, o_data, o_tag, o_src} !== {2'b00, {DW{1'b0}}, {TW{1'b0}}, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got v=%b b=%b d=%h t=%h s=%b want all zero",
               o_valid, busy, o_data, o_tag, o_src);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_ready got %b want 11", {r0_ready, r1_ready});
    end
    tick();
  endtask

  // Single op from requester 0 shows up one cycle later; priority moves to 1
  task automatic test_single_op();
    reset_dut();
    drive(1'b0, 1'b0, 1'b1, 32'h3F80_0000, 5'd5, 1'b0, '0, '0, 1'b1);
    #1;
    tests_run++;
    if (r0_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_r0_ready got %b want 1", r0_ready);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0001, 5'd1, 1'b1, 32'h0000_0002, 5'd2, 1'b0);
    #1;
    tests_run++;
    if ({o_valid, o_data, o_tag, o_src} !== {1'b1, 32'h3F80_0000, 5'd5, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL single_out got v=%b d=%h t=%0d s=%b want v=1 d=3f800000 t=5 s=0",
               o_valid, o_data, o_tag, o_src);
    end
    // Buffer full and stalled, so nobody is ready; release the stall to
    // observe the new priority.
    o_ready = 1'b1;
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL single_ptr got r0r1=%b want 01", {r0_ready, r1_ready});
    end
    tick();
  endtask

  // Both requesters valid every cycle: grants alternate at full rate
  task automatic test_alternate();
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      d0 = $urandom;
      d1 = $urandom;
      drive(1'b0, 1'b0, 1'b1, d0, 5'(2 * i), 1'b1, d1, 5'(2 * i + 1), 1'b1);
      #1;
      tests_run++;
      if ({r0_ready, r1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        tests_failed++;
        $display("[TB] FAIL alt_ready[%0d] got %b", i, {r0_ready, r1_ready});
      end
      tick();
      tests_run++;
      if ({o_valid, o_src, o_data, o_tag} !==
          {1'b1, 1'(i % 2), (i % 2 == 0) ? d0 : d1, 5'((i % 2 == 0) ? 2 * i : 2 * i + 1)}) begin
        tests_failed++;
        $display("[TB] FAIL alt_out[%0d] got v=%b s=%b d=%h t=%0d", i, o_valid, o_src, o_data, o_tag);
      end
    end
  endtask

  // Stall with a full buffer, then release: delivery and reload in one cycle
  task automatic test_backpressure();
    reset_dut();
    drive(1'b0, 1'b0, 1'b1, 32'hAAAA_5555, 5'd3, 1'b0, '0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 32'h1357_9BDF, 5'd7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if ({r0_ready, r1_ready, o_valid, o_tag, o_data, o_src} !==
          {2'b00, 1'b1, 5'd3, 32'hAAAA_5555, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL stall[%0d] got rdy=%b v=%b t=%0d d=%h s=%b", i,
                 {r0_ready, r1_ready}, o_valid, o_tag, o_data, o_src);
      end
      tick();
    end
    o_ready = 1'b1;
    #1;
    tests_run++;
    if (r1_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL release_r1_ready got %b want 1", r1_ready);
    end
    tick();
    r1_valid = 1'b0;
    #1;
    tests_run++;
    if ({o_valid, o_tag, o_data, o_src} !== {1'b1, 5'd7, 32'h1357_9BDF, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL release_out got v=%b t=%0d d=%h s=%b want v=1 t=7 d=13579bdf s=1",
               o_valid, o_tag, o_data, o_src);
    end
    tick();
  endtask

  // Flush drops the buffered op, blocks acceptance and keeps the pointer
  task automatic test_flush();
    reset_dut();
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd9, 1'b0, '0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h0BAD_0BAD, 5'd10, 1'b0, '0, '0, 1'b1);
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL flush_ready got %b want 00", {r0_ready, r1_ready});
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h1, 5'd1, 1'b1, 32'h2, 5'd2, 1'b1);
    #1;
    tests_run++;
    if ({o_valid, busy, r0_ready, r1_ready} !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL flush_after got v=%b busy=%b rdy=%b want v=0 busy=0 rdy=01",
               o_valid, busy, {r0_ready, r1_ready});
    end
    tick();
  endtask

  // Reset wins over a stalled full buffer
  task automatic test_reset_while_full();
    reset_dut();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0, '0, '0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h5, 5'd5, 1'b1, 32'h6, 5'd6, 1'b0);
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL rst_full_ready got %b want 00", {r0_ready, r1_ready});
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h5, 5'd5, 1'b1, 32'h6, 5'd6, 1'b1);
    #1;
    tests_run++;
    if ({o_valid, busy, o_data, o_tag, o_src, r0_ready, r1_ready} !==
        {2'b00, {DW{1'b0}}, {TW{1'b0}}, 1'b0, 2'b10}) begin
      tests_failed++;
      $display("[TB] FAIL rst_full_out got v=%b d=%h t=%0d s=%b rdy=%b", o_valid, o_data,
               o_tag, o_src, {r0_ready, r1_ready});
    end
    tick();
  endtask

  // A lone requester 1 is served even without priority; pointer returns to 0
  task automatic test_only_r1();
    reset_dut();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 32'h4040_0000, 5'd12, 1'b1);
    #1;
    tests_run++;
    if (r1_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL only_r1_ready got %b want 1", r1_ready);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h7, 5'd7, 1'b1, 32'h8, 5'd8, 1'b1);
    #1;
    tests_run++;
    if ({o_valid, o_src, o_tag, r0_ready, r1_ready} !== {1'b1, 1'b1, 5'd12, 2'b10}) begin
      tests_failed++;
      $display("[TB] FAIL only_r1_out got v=%b s=%b t=%0d rdy=%b want v=1 s=1 t=12 rdy=10",
               o_valid, o_src, o_tag, {r0_ready, r1_ready});
    end
    tick();
  endtask

  // Random traffic, resets, flushes and back-pressure against the model
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(31) == 0), ($urandom_range(15) == 0),
            ($urandom_range(3) != 0), $urandom, 5'($urandom),
            ($urandom_range(3) != 0), $urandom, 5'($urandom),
            ($urandom_range(3) != 0));
      #1;
      tests_run++;
      if ({r0_ready, r1_ready} !== {exp_ready(1'b0), exp_ready(1'b1)}) begin
        tests_failed++;
        $display("[TB] FAIL rand_ready[%0d] got %b want %b", i, {r0_ready, r1_ready},
                 {exp_ready(1'b0), exp_ready(1'b1)});
      end
      tick();
      tests_run++;
      if ({o_valid, busy, o_data, o_tag, o_src} !== {m_valid, m_valid, m_data, m_tag, m_src}) begin
        tests_failed++;
        $display("[TB] FAIL rand_out[%0d] got v=%b b=%b d=%h t=%0d s=%b want v=%b d=%h t=%0d s=%b",
                 i, o_valid, busy, o_data, o_tag, o_src, m_valid, m_data, m_tag, m_src);
      end
    end
  endtask

  initial begin
    m_valid = 1'b0; m_data = '0; m_tag = '0; m_src = 1'b0; m_ptr = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    test_reset();
    test_single_op();
    test_alternate();
    test_backpressure();
    test_flush();
    test_reset_while_full();
    test_only_r1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/e203_exu_fpu_fmis_arb.md
E203_EXU_FPU_FMIS_ARB -- requirements
Module: e203_exu_fpu_fmis_arb

Interface
REQ-001 Parameter DW, default 32: width of operand/writeback data.
REQ-002 Parameter TW, default 5: width of the writeback register tag.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush  input  1  synchronous pipeline flush; drops any buffered op.
REQ-006 r0_valid  input  1  requester 0 handshake valid.
REQ-007 r0_ready  output  1  requester 0 handshake ready.
REQ-008 r0_data  input  DW  requester 0 operand (rs1).
REQ-009 r0_tag  input  TW  requester 0 destination tag.
REQ-010 r1_valid, r1_ready, r1_data, r1_tag: same directions, widths and meaning as the r0_* ports, for requester 1.
REQ-011 o_valid  output  1  writeback handshake valid toward the fmis_mv datapath/writeback.
REQ-012 o_ready  input  1  writeback handshake ready.
REQ-013 o_data  output  DW  buffered operand of the granted op.
REQ-014 o_tag  output  TW  buffered tag of the granted op.
REQ-015 o_src  output  1  requester index (0/1) of the buffered op.
REQ-016 busy  output  1  high whenever an op is buffered (equals o_valid).

Function
REQ-017 The block SHALL arbitrate two requesters onto one shared fmis move datapath through a single output register (one-entry buffer).
REQ-018 Buffer state SHALL be EMPTY (o_valid=0) or FULL (o_valid=1).
REQ-019 can_accept SHALL be (EMPTY or (FULL and o_ready)) and not flush.
REQ-020 Round-robin pointer ptr (1 bit) SHALL mark the requester with priority.
REQ-021 rk_ready SHALL be can_accept and (ptr==k or other requester's valid low); rk_ready SHALL never depend on rk_valid itself.
REQ-022 Requester k is accepted in a cycle iff rk_valid and rk_ready; at most one requester SHALL be accepted per cycle.
REQ-023 On acceptance of k: next cycle o_valid=1, o_data/o_tag=rk_data/rk_tag, o_src=k, ptr=~k.
REQ-024 No acceptance: ptr SHALL hold.
REQ-025 Latency SHALL be exactly one cycle from acceptance to o_valid.
REQ-026 Throughput SHALL be one op per cycle while o_ready stays high (FULL with o_ready and new acceptance: reload, stay FULL).
REQ-027 FULL with o_ready and no acceptance: next state EMPTY.
REQ-028 FULL with o_ready low: o_valid, o_data, o_tag, o_src SHALL hold stable; no requester ready.
REQ-029 flush high: next cycle o_valid=0; no acceptance that cycle; ptr holds; an o_valid&o_ready beat in the flush cycle counts as delivered.
REQ-030 flush and rst both high: rst behaviour applies.
REQ-031 o_data/o_tag/o_src SHALL not change while EMPTY except on acceptance.

Reset
REQ-032 rst high at a clock edge SHALL set o_valid=0, busy=0, ptr=0, o_data=0, o_tag=0, o_src=0 on the next cycle, regardless of in-flight ops.
REQ-033 While rst is high, r0_ready and r1_ready SHALL be 0.
REQ-034 First cycle after rst deasserts, the block SHALL be EMPTY and both requesters eligible per REQ-021 with ptr=0.

Verification
REQ-035 Reset, r0_valid=1 data=0x3F800000 tag=5, o_ready=1 -> r0_ready=1; next cycle o_valid=1, o_data=0x3F800000, o_tag=5, o_src=0; ptr=1.
REQ-036 Both valid every cycle, o_ready=1, from reset -> grants alternate 0,1,0,1; o_src sequence 0,1,0,1 at one op per cycle.
REQ-037 Buffer FULL (tag 3), o_ready=0 for 4 cycles with r1_valid=1 -> r0/r1_ready=0, o_* stable at tag 3; o_ready=1 -> tag 3 delivered and r1 op accepted same cycle, appears next cycle.
REQ-038 FULL, flush=1 with r0_valid=1 -> r0_ready=0; next cycle o_valid=0, busy=0, ptr unchanged.
REQ-039 rst asserted while FULL and o_ready=0 -> next cycle o_valid=0, ptr=0, all o_* zero, no requester ready during rst.
REQ-040 Only r1_valid=1 with ptr=0 -> r1_ready=1 (other invalid), op accepted, ptr becomes 0.
